main_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `ram_main` (12-bit address, 16-bit data, clocked on `~clock`) between the processor and a secondary requester such as a loader or debug/DMA engine. The processor has fixed priority. A starvation counter forces one grant to the secondary requester after a bounded run of processor grants. The block sits between the requesters and the RAM's `data`/`wren`/`address`/`q` pins and returns registered read data to the granted requester.

---
 rtl/main_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_main_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter
//   Shares the single-port main RAM between the processor (port 0, fixed
//   priority) and a secondary requester (port 1, e.g. loader or DMA).
//   A starvation counter forces one port-1 grant after MAX_HOLD consecutive
//   port-0 grants while port 1 is waiting.
//
// Ports
//   clock, n_reset            system clock (rising edge), async active-low reset
//   pX_req/wren/addr/data     access request from port X
//   pX_gnt                    access issued this cycle (combinational)
//   pX_q, pX_qvalid           registered read data, one-cycle valid pulse
//   m_addr/m_data/m_wren      RAM drive (RAM itself is clocked on ~clock)
//   m_q                       RAM read data
module main_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_gnt,
  output logic [DATA_W-1:0] p0_q,
  output logic              p0_qvalid,
  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_gnt,
  output logic [DATA_W-1:0] p1_q,
  output logic              p1_qvalid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_wren,
  input  logic [DATA_W-1:0] m_q
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  logic [7:0]        hold_cnt;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;

  // Grants are gated by n_reset so an assertion kills the access at once,
  // without waiting for a clock edge.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (n_reset) begin
      if (p0_req && (!p1_req || (hold_cnt < HOLD_MAX))) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  // Granted port drives the RAM directly; when idle the last driven
  // address/data are held from registered copies.
  always_comb begin
    m_addr = addr_r;
    m_data = data_r;
    m_wren = 1'b0;
    if (p0_gnt) begin
      m_addr = p0_addr;
      m_data = p0_data;
      m_wren = p0_wren;
    end else if (p1_gnt) begin
      m_addr = p1_addr;
      m_data = p1_data;
      m_wren = p1_wren;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      addr_r <= '0;
      data_r <= '0;
    end else if (p0_gnt || p1_gnt) begin
      addr_r <= m_addr;
      data_r <= m_data;
    end
  end

  // Counts port-0 wins over a waiting port 1; any port-1 grant or a cycle
  // without p1_req restarts the count.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      hold_cnt <= '0;
    end else if (!p1_req || p1_gnt) begin
      hold_cnt <= '0;
    end else if (p0_gnt && (hold_cnt < HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  // The RAM presents read data at the falling edge inside the grant cycle,
  // so it is captured at the closing rising edge; q/qvalid appear the
  // following cycle and m_q never reaches an output combinationally.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      p0_q      <= '0;
      p0_qvalid <= 1'b0;
      p1_q      <= '0;
      p1_qvalid <= 1'b0;
    end else begin
      p0_qvalid <= p0_gnt && !p0_wren;
      p1_qvalid <= p1_gnt && !p1_wren;
      if (p0_gnt && !p0_wren) begin
        p0_q <= m_q;
      end
      if (p1_gnt && !p1_wren) begin
        p1_q <= m_q;
      end
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
module tb_main_mem_arbiter;

  logic        clock;
  logic        n_reset;
  logic        p0_req, p0_wren, p1_req, p1_wren;
  logic [11:0] p0_addr, p1_addr, m_addr;
  logic [15:0] p0_data, p1_data, m_data, m_q;
  logic        p0_gnt, p1_gnt, p0_qvalid, p1_qvalid, m_wren;
  logic [15:0] p0_q, p1_q;

  logic [15:0] mem [0:4095];

  int n_checks = 0;
  int n_errors = 0;

  main_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MAX_HOLD(8)) dut (
    .clock(clock), .n_reset(n_reset),
    .p0_req(p0_req), .p0_wren(p0_wren), .p0_addr(p0_addr), .p0_data(p0_data),
    .p0_gnt(p0_gnt), .p0_q(p0_q), .p0_qvalid(p0_qvalid),
    .p1_req(p1_req), .p1_wren(p1_wren), .p1_addr(p1_addr), .p1_data(p1_data),
    .p1_gnt(p1_gnt), .p1_q(p1_q), .p1_qvalid(p1_qvalid),
    .m_addr(m_addr), .m_data(m_data), .m_wren(m_wren), .m_q(m_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model clocked on the falling edge
  always @(negedge clock) begin
    if (m_wren) mem[m_addr] <= m_data;
    m_q <= mem[m_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem[i] = 16'h1000 + 16'(i);
    m_q = '0;
    n_reset = 1'b0;
    p0_req = 0; p0_wren = 0; p0_addr = '0; p0_data = '0;
    p1_req = 0; p1_wren = 0; p1_addr = '0; p1_data = '0;

    // reset state
    #2;
    chk("rst_p0_gnt", 32'(p0_gnt), 0);
    chk("rst_m_wren", 32'(m_wren), 0);
    chk("rst_p0_q", 32'(p0_q), 0);
    chk("rst_p1_q", 32'(p1_q), 0);
    chk("rst_qvalid", {30'd0, p1_qvalid, p0_qvalid}, 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_hold", 32'(dut.hold_cnt), 0);
    next_cyc();
    next_cyc();
    n_reset = 1'b1;

    // port 0 write then read
    next_cyc();
    p0_req = 1; p0_wren = 1; p0_addr = 12'h123; p0_data = 16'hBEEF;
    #2;
    chk("p0w_gnt", 32'(p0_gnt), 1);
    chk("p0w_wren", 32'(m_wren), 1);
    chk("p0w_addr", 32'(m_addr), 32'h123);
    chk("p0w_data", 32'(m_data), 32'hBEEF);
    next_cyc();
    p0_wren = 0;
    #2;
    chk("p0r_gnt", 32'(p0_gnt), 1);
    chk("p0r_wren", 32'(m_wren), 0);
    chk("p0w_noqv", 32'(p0_qvalid), 0);
    next_cyc();
    p0_req = 0; p0_addr = 12'h456; p0_data = 16'h0;
    #2;
    chk("p0r_qvalid", 32'(p0_qvalid), 1);
    chk("p0r_q", 32'(p0_q), 32'hBEEF);
    chk("idle_wren", 32'(m_wren), 0);
    chk("idle_addr_hold", 32'(m_addr), 32'h123);
    chk("idle_data_hold", 32'(m_data), 32'hBEEF);
    next_cyc();
    #2;
    chk("p0r_qv_pulse", 32'(p0_qvalid), 0);
    chk("p0_q_hold", 32'(p0_q), 32'hBEEF);

    // port 1 back-to-back reads
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      p1_req = 1; p1_wren = 0; p1_addr = 12'(i);
      #2;
      chk("p1b_gnt", 32'(p1_gnt), 1);
      chk("p1b_p0gnt", 32'(p0_gnt), 0);
      chk("p1b_p0qv", 32'(p0_qvalid), 0);
      if (i == 0) chk("p1b_qv0", 32'(p1_qvalid), 0);
      else begin
        chk("p1b_qv", 32'(p1_qvalid), 1);
        chk("p1b_q", 32'(p1_q), 32'h1000 + 32'(i - 1));
      end
    end
    next_cyc();
    p1_req = 0;
    #2;
    chk("p1b_qv_last", 32'(p1_qvalid), 1);
    chk("p1b_q_last", 32'(p1_q), 32'h1003);
    next_cyc();
    #2;
    chk("p1b_qv_end", 32'(p1_qvalid), 0);

    // starvation: both requesting continuously
    for (int k = 0; k < 26; k++) begin
      next_cyc();
      p0_req = 1; p0_wren = 0; p0_addr = 12'h001;
      p1_req = 1; p1_wren = 0; p1_addr = 12'h002;
      #2;
      chk("stv_hold", 32'(dut.hold_cnt), 32'(k % 9));
      chk("stv_p1gnt", 32'(p1_gnt), 32'((k % 9) == 8));
      chk("stv_p0gnt", 32'(p0_gnt), 32'((k % 9) != 8));
    end
    next_cyc();
    p0_req = 0; p1_req = 0;
    #2;
    chk("stv_hold_sat", 32'(dut.hold_cnt), 8);
    chk("stv_idle_gnt", {30'd0, p1_gnt, p0_gnt}, 0);
    next_cyc();
    #2;
    chk("stv_hold_clr", 32'(dut.hold_cnt), 0);

    // contention with port-0 dropout
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      p0_req = (k < 3); p0_wren = 0; p0_addr = 12'h001;
      p1_req = 1; p1_wren = 0; p1_addr = 12'h003;
      #2;
      chk("cd_p0gnt", 32'(p0_gnt), 32'(k < 3));
      chk("cd_p1gnt", 32'(p1_gnt), 32'(k == 3));
      chk("cd_hold", 32'(dut.hold_cnt), 32'(k));
    end
    next_cyc();
    p0_req = 0; p1_req = 0;
    #2;
    chk("cd_hold_clr", 32'(dut.hold_cnt), 0);
    chk("cd_p1qv", 32'(p1_qvalid), 1);
    chk("cd_p1q", 32'(p1_q), 32'h1003);

    // port 1 write, port 0 reads it back next cycle
    next_cyc();
    p1_req = 1; p1_wren = 1; p1_addr = 12'hFFF; p1_data = 16'h5A5A;
    #2;
    chk("wi_p1gnt", 32'(p1_gnt), 1);
    chk("wi_wren", 32'(m_wren), 1);
    chk("wi_addr", 32'(m_addr), 32'hFFF);
    chk("wi_data", 32'(m_data), 32'h5A5A);
    next_cyc();
    p1_req = 0; p1_wren = 0;
    p0_req = 1; p0_wren = 0; p0_addr = 12'hFFF;
    #2;
    chk("wi_p0gnt", 32'(p0_gnt), 1);
    chk("wi_rd_wren", 32'(m_wren), 0);
    chk("wi_p1qv_a", 32'(p1_qvalid), 0);
    next_cyc();
    p0_req = 0;
    #2;
    chk("wi_p0qv", 32'(p0_qvalid), 1);
    chk("wi_p0q", 32'(p0_q), 32'h5A5A);
    chk("wi_p1qv_b", 32'(p1_qvalid), 0);

    // reset asserted in the middle of a read grant
    next_cyc();
    p0_req = 1; p0_wren = 0; p0_addr = 12'h123;
    #2;
    chk("rm_gnt_pre", 32'(p0_gnt), 1);
    n_reset = 1'b0;
    #1;
    chk("rm_p0gnt", 32'(p0_gnt), 0);
    chk("rm_wren", 32'(m_wren), 0);
    chk("rm_p0q", 32'(p0_q), 0);
    chk("rm_p1q", 32'(p1_q), 0);
    chk("rm_addr", 32'(m_addr), 0);
    p0_req = 0;
    next_cyc();
    next_cyc();
    n_reset = 1'b1;
    #2;
    chk("rm_qv_a", 32'(p0_qvalid), 0);
    next_cyc();
    #2;
    chk("rm_qv_b", 32'(p0_qvalid), 0);
    chk("rm_p0q_after", 32'(p0_q), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
